// File: rtl/oled_text_sequencer.sv
// Text-frame sequencer: walks a PAGES x COLS ASCII buffer, looks up 8x8 glyphs, streams page commands + glyph columns.
// Latency: first command byte valid the cycle after start is taken; 147 cycles per page with tx_ready held high.
// Backpressure: tx_ready low freezes the stream and all counters with tx_byte/tx_dc held; the one-cycle FETCH never stalls.
module oled_text_sequencer #(
  parameter int         PAGES = 4,
  parameter int         COLS  = 16,
  parameter logic [6:0] BLANK = 7'h20
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_wr_en,
  input  logic [$clog2(PAGES*COLS)-1:0] i_wr_addr,
  input  logic [6:0]                    i_wr_char,
  input  logic                          i_start,
  output logic [6:0]                    o_rom_addr,
  input  logic [63:0]                   i_rom_data,
  output logic [7:0]                    o_tx_byte,
  output logic                          o_tx_dc,
  output logic                          o_tx_valid,
  input  logic                          i_tx_ready,
  output logic                          o_busy,
  output logic                          o_done
);

  // PAGES and COLS are powers of two (>= 2), so the buffer index is just {page, col}.
  localparam int PW    = $clog2(PAGES);
  localparam int CW    = $clog2(COLS);
  localparam int AW    = PW + CW;
  localparam int DEPTH = PAGES * COLS;

  localparam logic [PW-1:0] LAST_PAGE = PW'(PAGES - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_FETCH,
    S_DATA,
    S_DONE
  } state_t;

  logic [6:0]    r_buf [DEPTH];
  state_t        r_state;
  logic [PW-1:0] r_page;
  logic [CW-1:0] r_col;
  logic [1:0]    r_cmd_idx;
  logic [2:0]    r_byte_idx;
  // Only the seven columns still to be sent; column 0 goes straight into r_tx_byte.
  logic [55:0]   r_shift;
  logic [6:0]    r_rom_addr;
  logic [7:0]    r_tx_byte;
  logic          r_tx_dc;
  logic          r_tx_valid;
  logic          r_busy;
  logic          r_done;

  logic [AW-1:0] w_fetch_idx;
  logic [6:0]    w_fetch_char;
  logic          w_accept;

  assign w_fetch_idx  = {r_page, r_col};
  assign w_fetch_char = r_buf[w_fetch_idx];
  assign w_accept     = r_tx_valid & i_tx_ready;

  // ROM is combinational: present the live buffer entry during FETCH, otherwise hold the last one used.
  assign o_rom_addr = (r_state == S_FETCH) ? w_fetch_char : r_rom_addr;
  assign o_tx_byte  = r_tx_byte;
  assign o_tx_dc    = r_tx_dc;
  assign o_tx_valid = r_tx_valid;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

  // Host text buffer: writes land at the edge, so a same-cycle FETCH of that entry sees the old character.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= BLANK;
      end
    end else if (i_wr_en) begin
      r_buf[i_wr_addr] <= i_wr_char;
    end
  end

  // Frame walker: command group per page, then FETCH + 8 glyph columns per character, all outputs registered.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_page     <= '0;
      r_col      <= '0;
      r_cmd_idx  <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_rom_addr <= '0;
      r_tx_byte  <= '0;
      r_tx_dc    <= 1'b0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_CMD;
            r_page     <= '0;
            r_col      <= '0;
            r_cmd_idx  <= '0;
            r_busy     <= 1'b1;
            r_tx_valid <= 1'b1;
            r_tx_dc    <= 1'b0;
            r_tx_byte  <= 8'hB0;
          end
        end

        S_CMD: begin
          if (w_accept) begin
            if (r_cmd_idx == 2'd2) begin
              r_tx_valid <= 1'b0;
              r_state    <= S_FETCH;
            end else begin
              // Page-start command is followed by lower then upper column-start nibbles (both zero).
              r_cmd_idx <= r_cmd_idx + 2'd1;
              r_tx_byte <= (r_cmd_idx == 2'd0) ? 8'h00 : 8'h10;
            end
          end
        end

        S_FETCH: begin
          r_rom_addr <= w_fetch_char;
          r_shift    <= i_rom_data[55:0];
          r_byte_idx <= '0;
          r_tx_byte  <= i_rom_data[63:56];
          r_tx_dc    <= 1'b1;
          r_tx_valid <= 1'b1;
          r_state    <= S_DATA;
        end

        S_DATA: begin
          if (w_accept) begin
            r_shift <= {r_shift[47:0], 8'h00};
            if (r_byte_idx != 3'd7) begin
              r_byte_idx <= r_byte_idx + 3'd1;
              r_tx_byte  <= r_shift[55:48];
            end else if (r_col != LAST_COL) begin
              r_col      <= r_col + CW'(1);
              r_tx_valid <= 1'b0;
              r_state    <= S_FETCH;
            end else if (r_page != LAST_PAGE) begin
              // Next page's first command follows the last data byte with no bubble.
              r_col     <= '0;
              r_page    <= r_page + PW'(1);
              r_cmd_idx <= '0;
              r_tx_dc   <= 1'b0;
              r_tx_byte <= 8'hB0 | 8'(r_page + PW'(1));
              r_state   <= S_CMD;
            end else begin
              r_tx_valid <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled_text_sequencer.sv
// Bench for oled_text_sequencer: bench-side glyph ROM, frame-level byte-queue model, per-cycle compare process.
module tb_oled_text_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [6:0]  wr_char = '0;
  logic        start = 1'b0;
  logic [6:0]  rom_addr;
  logic [63:0] rom_data;
  logic [7:0]  tx_byte;
  logic        tx_dc;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  oled_text_sequencer dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_char  (wr_char),
    .i_start    (start),
    .o_rom_addr (rom_addr),
    .i_rom_data (rom_data),
    .o_tx_byte  (tx_byte),
    .o_tx_dc    (tx_dc),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_busy     (busy),
    .o_done     (done)
  );

  // Glyph ROM: the three glyphs the checks rely on, plus a distinct pattern for every other code.
  function automatic logic [63:0] glyph(input logic [6:0] c);
    case (c)
      7'h20:   return 64'h0;
      7'h41:   return 64'h407c4a094a7c4000;
      7'h5A:   return 64'h4361514945436100;
      default: return {8{1'b1, c}} ^ 64'h0f1e2d3c4b5a6978;
    endcase
  endfunction

  assign rom_data = glyph(rom_addr);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  logic [7:0] a_tab [8] = '{8'h40, 8'h7c, 8'h4a, 8'h09, 8'h4a, 8'h7c, 8'h40, 8'h00};
  logic [7:0] z_tab [8] = '{8'h43, 8'h61, 8'h51, 8'h49, 8'h45, 8'h43, 8'h61, 8'h00};

  // Model: text buffer and the expected {dc, byte} stream of the current frame.
  logic [6:0] m_buf [64];
  logic [8:0] exp_q [$];
  logic [8:0] cap [$];
  int  n_acc = 0;
  int  n_done = 0;
  bit  frame_active = 0;
  int  cyc = 0;
  int  start_cyc = 0;
  int  rel;
  int  busy_rel, valid_rel, data_rel, last_rel, done_rel, drop_rel;
  bit  prev_stall = 0;
  logic [8:0] prev_dat = '0;
  bit  rnd_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Stream position of a character's first data byte: 131 bytes per page, 3 commands, 8 bytes per char.
  function automatic int first_pos(input int a);
    return (a / 16) * 131 + 3 + (a % 16) * 8;
  endfunction

  task automatic build_frame();
    logic [63:0] g;
    exp_q.delete();
    for (int p = 0; p < 4; p++) begin
      exp_q.push_back({1'b0, 8'hB0 + 8'(p)});
      exp_q.push_back({1'b0, 8'h00});
      exp_q.push_back({1'b0, 8'h10});
      for (int c = 0; c < 16; c++) begin
        g = glyph(m_buf[p * 16 + c]);
        for (int b = 0; b < 8; b++) exp_q.push_back({1'b1, g[63 - 8 * b -: 8]});
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_buf[i] = 7'h20;
    exp_q.delete();
    frame_active = 0;
  endtask

  // A write to a character whose data has not started yet changes what the frame must send.
  task automatic do_write(input int a, input logic [6:0] c);
    int idx;
    logic [63:0] g;
    wr_en   = 1'b1;
    wr_addr = 6'(a);
    wr_char = c;
    m_buf[a] = c;
    if (frame_active) begin
      idx = first_pos(a) - n_acc;
      if (idx > 0 && idx + 8 <= exp_q.size()) begin
        g = glyph(c);
        for (int b = 0; b < 8; b++) exp_q[idx + b] = {1'b1, g[63 - 8 * b -: 8]};
      end
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic start_frame();
    cap.delete();
    n_acc = 0;
    busy_rel = -1; valid_rel = -1; data_rel = -1; last_rel = -1; done_rel = -1; drop_rel = -1;
    build_frame();
    frame_active = 1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_rel(input int r);
    int i = 0;
    while ((cyc - start_cyc) < r && i < 2000) begin
      @(posedge clk); #1;
      i++;
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0 = n_done;
    int i = 0;
    while (n_done == d0 && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    check(name, n_done - d0, 1);
  endtask

  // Per-cycle compare: handshake stability, accepted bytes against the model, frame length at done.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      rel = cyc - start_cyc;
      if (prev_stall) check("hold_stable", {tx_valid, tx_dc, tx_byte}, {1'b1, prev_dat});
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) check("queue_depth", exp_q.size(), 1);
        else check("stream_byte", {tx_dc, tx_byte}, exp_q.pop_front());
        cap.push_back({tx_dc, tx_byte});
        n_acc++;
        last_rel = rel;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_dat   = {tx_dc, tx_byte};
      if (busy && busy_rel < 0) busy_rel = rel;
      if (tx_valid && valid_rel < 0) valid_rel = rel;
      if (tx_valid && tx_dc && data_rel < 0) data_rel = rel;
      if (busy_rel >= 0 && !busy && drop_rel < 0) drop_rel = rel;
      if (done) begin
        n_done++;
        done_rel = rel;
        check("frame_len", n_acc, 524);
        check("frame_left", exp_q.size(), 0);
        frame_active = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int nz;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_tx_dc", tx_dc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rom_addr", rom_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Blank frame, tx_ready high: cycle-exact timing
    start_frame();
    wait_done(1000, "t1_done");
    repeat (3) @(posedge clk); #1;
    check("t1_busy_cycle", busy_rel, 1);
    check("t1_first_valid", valid_rel, 1);
    check("t1_first_data", data_rel, 5);
    check("t1_last_byte", last_rel, 588);
    check("t1_done_cycle", done_rel, 589);
    check("t1_busy_drop", drop_rel, 590);
    check("t1_cap0", cap[0], 9'h0B0);
    check("t1_cap1", cap[1], 9'h000);
    check("t1_cap2", cap[2], 9'h010);
    check("t1_cap3", cap[3], 9'h100);
    check("t1_cap131", cap[131], 9'h0B1);
    check("t1_count", cap.size(), 524);
    check("t1_rom_hold", rom_addr, 7'h20);

    // 'A' at address 0
    do_write(0, 7'h41);
    start_frame();
    wait_done(1000, "t2_done");
    for (int i = 0; i < 8; i++) check("t2_glyph_A", cap[3 + i], {1'b1, a_tab[i]});

    // Random tx_ready stalls
    rnd_ready = 1;
    start_frame();
    wait_done(4000, "t3_done");
    rnd_ready = 0;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    check("t3_count", cap.size(), 524);

    // Mid-frame writes: addr 17 not yet fetched, addr 0 already sent
    start_frame();
    begin
      int i = 0;
      while (n_acc < 45 && i < 300) begin
        @(posedge clk); #1;
        i++;
      end
    end
    do_write(17, 7'h5A);
    do_write(0, 7'h5A);
    wait_done(1000, "t4_done");
    for (int i = 0; i < 8; i++) check("t4_glyph_Z", cap[142 + i], {1'b1, z_tab[i]});
    for (int i = 0; i < 8; i++) check("t4_sent_A", cap[3 + i], {1'b1, a_tab[i]});

    // start pulses while busy are ignored
    d0 = n_done;
    start_frame();
    wait_rel(10);
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    wait_rel(300);
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    wait_done(1000, "t5_done");
    repeat (50) @(posedge clk); #1;
    check("t5_one_done", n_done - d0, 1);
    check("t5_done_cycle", done_rel, 589);
    check("t5_idle_busy", busy, 0);

    // Reset mid-frame
    d0 = n_done;
    start_frame();
    wait_rel(200);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_valid_drop", tx_valid, 0);
    check("t6_busy_drop", busy, 0);
    repeat (700) @(posedge clk); #1;
    check("t6_no_done", n_done - d0, 0);
    start_frame();
    wait_done(1000, "t6_done");
    nz = 0;
    foreach (cap[i]) if (cap[i][8] && cap[i][7:0] != 8'h00) nz++;
    check("t6_blank_data", nz, 0);
    check("t6_count", cap.size(), 524);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
